// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code sweep controller: controller states,
// default widths and the binary-to-Gray conversion.
package gray_pkg;

    // Default width of the Gray position output.
    localparam int W_DEFAULT  = 3;
    // Default width of the sweep-length input.
    localparam int LW_DEFAULT = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Binary to reflected Gray code. Callers zero-extend into 32 bits and
    // truncate the result back to their own width.
    function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_enc.sv
// Purely combinational binary-to-Gray encoder driving the position output.
module gray_enc
    import gray_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] q
);

    assign q = W'(bin_to_gray(32'(bin)));

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Gray-code position sweeper. A sweep is requested with start and a non-zero
// length, then steps a binary position up or down once per cycle until the
// length is used up. The sweep can be paused with hold or aborted with stop.
// The position persists between sweeps and is shown on q in Gray code.
module gray_sweep_ctrl
    import gray_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int LW = LW_DEFAULT
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          stop,
    input  logic          hold,
    input  logic          dir,
    input  logic [LW-1:0] len,
    output logic [W-1:0]  q,
    output logic          busy,
    output logic          done,
    output logic          wrap
);

    state_t        state;
    logic [W-1:0]  bin;
    logic [LW-1:0] rem;
    logic          dir_l;

    // Step outcome used by the RUN branch: next position and whether that
    // step crosses the end of the position range.
    logic [W-1:0]  bin_next;
    logic          bin_wraps;

    // Next position and wrap detection for a single step in the latched direction.
    always_comb begin
        bin_next  = bin;
        bin_wraps = 1'b0;
        if (dir_l) begin
            bin_next  = bin - W'(1);
            bin_wraps = (bin == '0);
        end else begin
            bin_next  = bin + W'(1);
            bin_wraps = (bin == '1);
        end
    end

    // Sweep state machine; busy, done and wrap are registered alongside the
    // state so they come straight from flops and cannot glitch.
    // NOTE: every register here uses <= so all of them sample the pre-edge
    // values of each other; a blocking = would let later lines see updated state.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: reset is asynchronous and clears every register, including
        // the position, so the block is fully defined the moment n_rst drops.
        if (!n_rst) begin
            state <= ST_IDLE;
            bin   <= '0;
            rem   <= '0;
            dir_l <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A zero-length request is silently dropped.
                    if (start && (len != '0)) begin
                        rem   <= len;
                        dir_l <= dir;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (hold) begin
                        state <= ST_PAUSE;
                    end else begin
                        bin  <= bin_next;
                        rem  <= rem - LW'(1);
                        wrap <= bin_wraps;
                        // The step that consumes the last count ends the sweep.
                        if (rem <= LW'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    // stop outranks hold; leaving PAUSE never takes a step.
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (!hold) begin
                        state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Single-cycle completion state; start is not looked at here.
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    gray_enc #(
        .W(W)
    ) u_gray_enc (
        .bin(bin),
        .q  (q)
    );

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Self-checking bench for gray_sweep_ctrl: a behavioural model checked against
// the DUT on every falling edge, plus hand-computed literal vectors that pin
// both the DUT and the model through the directed scenarios.
module tb_gray_sweep_ctrl;

    localparam int W  = 3;
    localparam int LW = 4;
    localparam int N  = 1 << W;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic          stop;
    logic          hold;
    logic          dir;
    logic [LW-1:0] len;
    logic [W-1:0]  q;
    logic          busy;
    logic          done;
    logic          wrap;

    int n_pass  = 0;
    int n_total = 0;

    gray_sweep_ctrl #(
        .W (W),
        .LW(LW)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .start(start),
        .stop (stop),
        .hold (hold),
        .dir  (dir),
        .len  (len),
        .q    (q),
        .busy (busy),
        .done (done),
        .wrap (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Behavioural model: a position on a ring of N slots, a count of steps
    // still owed, and flags for "sweep active", "paused", and the one-cycle
    // done / wrap events.
    // ------------------------------------------------------------------
    int m_pos    = 0;
    int m_left   = 0;
    bit m_active = 0;
    bit m_paused = 0;
    bit m_down   = 0;
    bit m_done   = 0;
    bit m_wrap   = 0;

    function automatic int gray_of(input int v);
        return v ^ (v >> 1);
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_pos    <= 0;
            m_left   <= 0;
            m_active <= 0;
            m_paused <= 0;
            m_down   <= 0;
            m_done   <= 0;
            m_wrap   <= 0;
        end else begin
            m_done <= 0;
            m_wrap <= 0;
            if (m_active) begin
                if (stop) begin
                    m_active <= 0;
                    m_paused <= 0;
                end else if (m_paused) begin
                    if (!hold) m_paused <= 0;
                end else if (hold) begin
                    m_paused <= 1;
                end else begin
                    m_pos  <= m_down ? (m_pos + N - 1) % N : (m_pos + 1) % N;
                    m_wrap <= m_down ? (m_pos == 0) : (m_pos == N - 1);
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_active <= 0;
                        m_done   <= 1;
                    end
                end
            end else if (!m_done) begin
                if (start && (int'(len) != 0)) begin
                    m_active <= 1;
                    m_left   <= int'(len);
                    m_down   <= dir;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Continuous model-vs-DUT comparison, away from the rising edge.
    always @(negedge clk) begin
        check("model_q",    int'(q),    gray_of(m_pos));
        check("model_busy", int'(busy), int'(m_active));
        check("model_done", int'(done), int'(m_done));
        check("model_wrap", int'(wrap), int'(m_wrap));
    end

    // Literal expectation for the current cycle, applied to DUT and model.
    task automatic expect_lit(input string name, input int eq, input int eb,
                              input int ed, input int ew);
        check({name, "_q"},    int'(q),    eq);
        check({name, "_busy"}, int'(busy), eb);
        check({name, "_done"}, int'(done), ed);
        check({name, "_wrap"}, int'(wrap), ew);
        check({name, "_mq"},   gray_of(m_pos), eq);
        check({name, "_mdone"}, int'(m_done), ed);
        check({name, "_mwrap"}, int'(m_wrap), ew);
    endtask

    // Apply one cycle of inputs, let the rising edge pass, settle.
    task automatic cyc(input bit s, input bit sp, input bit h, input bit d, input int l);
        start = s;
        stop  = sp;
        hold  = h;
        dir   = d;
        len   = LW'(l);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0);
    endtask

    // Pulse reset off-edge and confirm the outputs clear immediately.
    task automatic pulse_reset(input string name);
        n_rst = 1'b0;
        #1;
        check({name, "_q"},    int'(q),    0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_wrap"}, int'(wrap), 0);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        hold  = 1'b0;
        dir   = 1'b0;
        len   = '0;
        #1;
        pulse_reset("reset");

        // Sweep of 5 up from 0; start during DONE must be ignored.
        cyc(1, 0, 0, 0, 5);  expect_lit("s5_start", 3'b000, 1, 0, 0);
        idle_cyc();          expect_lit("s5_1",     3'b001, 1, 0, 0);
        idle_cyc();          expect_lit("s5_2",     3'b011, 1, 0, 0);
        idle_cyc();          expect_lit("s5_3",     3'b010, 1, 0, 0);
        idle_cyc();          expect_lit("s5_4",     3'b110, 1, 0, 0);
        cyc(1, 0, 0, 0, 3);  expect_lit("s5_5",     3'b111, 0, 1, 0);
        idle_cyc();          expect_lit("s5_idle",  3'b111, 0, 0, 0);
        idle_cyc();          expect_lit("s5_nostart", 3'b111, 0, 0, 0);

        // One step up to reach position 6.
        cyc(1, 0, 0, 0, 1);  expect_lit("to6_start", 3'b111, 1, 0, 0);
        idle_cyc();          expect_lit("to6_step",  3'b101, 0, 1, 0);
        idle_cyc();

        // Up-wrap: 6 -> 7 -> 0 -> 1.
        cyc(1, 0, 0, 0, 3);  expect_lit("wup_start", 3'b101, 1, 0, 0);
        idle_cyc();          expect_lit("wup_1",     3'b100, 1, 0, 0);
        idle_cyc();          expect_lit("wup_2",     3'b000, 1, 0, 1);
        idle_cyc();          expect_lit("wup_3",     3'b001, 0, 1, 0);
        idle_cyc();          expect_lit("wup_idle",  3'b001, 0, 0, 0);

        // One step down to position 0 (1 -> 0 is not a wrap).
        cyc(1, 0, 0, 1, 1);  expect_lit("to0_start", 3'b001, 1, 0, 0);
        idle_cyc();          expect_lit("to0_step",  3'b000, 0, 1, 0);
        idle_cyc();

        // Down-wrap: 0 -> 7 in a single-step sweep.
        cyc(1, 0, 0, 1, 1);  expect_lit("wdn_start", 3'b000, 1, 0, 0);
        idle_cyc();          expect_lit("wdn_step",  3'b100, 0, 1, 1);
        idle_cyc();          expect_lit("wdn_idle",  3'b100, 0, 0, 0);

        // Pause: len 4 up, hold for three edges after the 2nd step.
        pulse_reset("rst_pause");
        cyc(1, 0, 0, 0, 4);  expect_lit("p_start", 3'b000, 1, 0, 0);
        idle_cyc();          expect_lit("p_1",     3'b001, 1, 0, 0);
        idle_cyc();          expect_lit("p_2",     3'b011, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);  expect_lit("p_h1",    3'b011, 1, 0, 0);
        cyc(1, 0, 1, 1, 9);  expect_lit("p_h2",    3'b011, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);  expect_lit("p_h3",    3'b011, 1, 0, 0);
        idle_cyc();          expect_lit("p_resume", 3'b011, 1, 0, 0);
        idle_cyc();          expect_lit("p_3",     3'b010, 1, 0, 0);
        idle_cyc();          expect_lit("p_4",     3'b110, 0, 1, 0);
        idle_cyc();          expect_lit("p_idle",  3'b110, 0, 0, 0);

        // Stop with hold after the 2nd step of len 6; then len 0 is ignored.
        pulse_reset("rst_stop");
        cyc(1, 0, 0, 0, 6);  expect_lit("st_start", 3'b000, 1, 0, 0);
        idle_cyc();          expect_lit("st_1",     3'b001, 1, 0, 0);
        idle_cyc();          expect_lit("st_2",     3'b011, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);  expect_lit("st_stop",  3'b011, 0, 0, 0);
        idle_cyc();          expect_lit("st_idle",  3'b011, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);  expect_lit("st_len0",  3'b011, 0, 0, 0);
        idle_cyc();          expect_lit("st_len0b", 3'b011, 0, 0, 0);

        // Reset mid-sweep, then a start on the first edge after release.
        cyc(1, 0, 0, 0, 6);  expect_lit("mr_start", 3'b011, 1, 0, 0);
        idle_cyc();          expect_lit("mr_1",     3'b010, 1, 0, 0);
        idle_cyc();          expect_lit("mr_2",     3'b110, 1, 0, 0);
        pulse_reset("rst_mid");
        cyc(1, 0, 0, 0, 2);  expect_lit("mr_restart", 3'b000, 1, 0, 0);
        idle_cyc();          expect_lit("mr_r1",    3'b001, 1, 0, 0);
        idle_cyc();          expect_lit("mr_r2",    3'b011, 0, 1, 0);
        idle_cyc();          expect_lit("mr_idle",  3'b011, 0, 0, 0);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
